dcache_ctrl: RTL

- Direct-mapped, write-back, write-allocate data cache sitting in the MEM stage, between the core's data port and the main-memory bus.
- Produces the DCacheMiss signal consumed by the hazard unit. While a miss is outstanding, the hazard unit stalls the pipeline.
- Fills and writes back lines one word at a time over a req/gnt memory handshake.
- Keeps hit and miss performance counters.

---
 rtl/dcache_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache for the MEM stage.
// Refills and write-backs move one word per req/gnt handshake.
module dcache_ctrl #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int SET_ADDR_LEN  = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic [31:0] addr,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_be,
    output logic [31:0] rd_data,
    output logic        miss,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_gnt,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int TAG_LEN = 30 - LINE_ADDR_LEN - SET_ADDR_LEN;
    localparam int WORDS   = 1 << LINE_ADDR_LEN;
    localparam int SETS    = 1 << SET_ADDR_LEN;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WB   = 2'd1;
    localparam logic [1:0] FILL = 2'd2;

    localparam logic [LINE_ADDR_LEN-1:0] CNT_ZERO = {LINE_ADDR_LEN{1'b0}};
    localparam logic [LINE_ADDR_LEN-1:0] CNT_ONE  =
        {{(LINE_ADDR_LEN-1){1'b0}}, 1'b1};

    logic [31:0]              data_arr [SETS][WORDS];
    logic [TAG_LEN-1:0]       tag_arr  [SETS];
    logic [SETS-1:0]          valid;
    logic [SETS-1:0]          dirty;

    logic [1:0]               state;
    logic [LINE_ADDR_LEN-1:0] cnt;
    logic [LINE_ADDR_LEN-1:0] cnt_nxt;
    logic                     last;
    logic                     just_filled;
    logic [TAG_LEN-1:0]       req_tag;
    logic [TAG_LEN-1:0]       vic_tag;
    logic [SET_ADDR_LEN-1:0]  req_set;

    logic [TAG_LEN-1:0]       tag;
    logic [SET_ADDR_LEN-1:0]  set;
    logic [LINE_ADDR_LEN-1:0] word;
    logic                     req;
    logic                     hit;
    logic                     unused_addr;

    assign tag  = addr[31 -: TAG_LEN];
    assign set  = addr[SET_ADDR_LEN+LINE_ADDR_LEN+1 : LINE_ADDR_LEN+2];
    assign word = addr[LINE_ADDR_LEN+1 : 2];
    assign unused_addr = ^addr[1:0];

    assign req     = rd_req | wr_req;
    assign hit     = valid[set] && (tag_arr[set] == tag);
    assign miss    = req && !(state == IDLE && hit);
    assign rd_data = data_arr[set][word];
    assign cnt_nxt = cnt + CNT_ONE;
    assign last    = (cnt == {LINE_ADDR_LEN{1'b1}});

    // Data and tag storage: store-hit byte merge and refill word capture
    always_ff @(posedge clk) begin
        if (state == IDLE && wr_req && hit) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    data_arr[set][word][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
        if (state == FILL && mem_gnt) begin
            data_arr[req_set][cnt] <= mem_rdata;
            if (last) begin
                tag_arr[req_set] <= req_tag;
            end
        end
    end

    // Control FSM, line status bits, memory bus and performance counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= CNT_ZERO;
            just_filled <= 1'b0;
            valid       <= '0;
            dirty       <= '0;
            req_tag     <= '0;
            vic_tag     <= '0;
            req_set     <= '0;
            hit_count   <= 32'd0;
            miss_count  <= 32'd0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 32'd0;
            mem_wdata   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    just_filled <= 1'b0;
                    if (req && hit) begin
                        if (!just_filled) begin
                            hit_count <= hit_count + 32'd1;
                        end
                        if (wr_req) begin
                            dirty[set] <= 1'b1;
                        end
                    end else if (req) begin
                        miss_count <= miss_count + 32'd1;
                        cnt        <= CNT_ZERO;
                        req_tag    <= tag;
                        req_set    <= set;
                        vic_tag    <= tag_arr[set];
                        valid[set] <= 1'b0;
                        mem_req    <= 1'b1;
                        if (valid[set] && dirty[set]) begin
                            state     <= WB;
                            mem_we    <= 1'b1;
                            mem_addr  <= {tag_arr[set], set, CNT_ZERO, 2'b00};
                            mem_wdata <= data_arr[set][0];
                        end else begin
                            state    <= FILL;
                            mem_we   <= 1'b0;
                            mem_addr <= {tag, set, CNT_ZERO, 2'b00};
                        end
                    end
                end
                WB: begin
                    if (mem_gnt) begin
                        if (last) begin
                            cnt      <= CNT_ZERO;
                            state    <= FILL;
                            mem_we   <= 1'b0;
                            mem_addr <= {req_tag, req_set, CNT_ZERO, 2'b00};
                        end else begin
                            cnt       <= cnt_nxt;
                            mem_addr  <= {vic_tag, req_set, cnt_nxt, 2'b00};
                            mem_wdata <= data_arr[req_set][cnt_nxt];
                        end
                    end
                end
                FILL: begin
                    if (mem_gnt) begin
                        if (last) begin
                            cnt            <= CNT_ZERO;
                            state          <= IDLE;
                            mem_req        <= 1'b0;
                            valid[req_set] <= 1'b1;
                            dirty[req_set] <= 1'b0;
                            just_filled    <= 1'b1;
                        end else begin
                            cnt      <= cnt_nxt;
                            mem_addr <= {req_tag, req_set, cnt_nxt, 2'b00};
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
